// File: rtl/argmax_pkg.sv
// Shared types and the tie-aware compare used by argmax_stream and its lane tree.
// Optional ARGMAX_TIE_LOW_EN: ties resolve to the lowest class index instead of the highest.
package argmax_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam int IDX_W = 32;

  // Scores arrive sign-extended to 64 bits so one function serves every DATA_W.
  function automatic logic better(
    input logic signed [63:0]   cand,
    input logic [IDX_W-1:0]     cand_idx,
    input logic signed [63:0]   best,
    input logic [IDX_W-1:0]     best_idx
  );
    logic res;
    if (cand_idx > best_idx) begin
`ifdef ARGMAX_TIE_LOW_EN
      res = (cand > best);
`else
      res = (cand >= best);
`endif
    end else begin
`ifdef ARGMAX_TIE_LOW_EN
      res = (cand >= best);
`else
      res = (cand > best);
`endif
    end
    return res;
  endfunction

endpackage

// File: rtl/argmax_stream_lane_tree.sv
// Combinational reduction of one input beat to its best lane (score and lane offset).
// Tie policy follows ARGMAX_TIE_LOW_EN through argmax_pkg::better.
module argmax_lane_tree
  import argmax_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANES  = 2
) (
  input  logic [LANES*DATA_W-1:0] lanes,
  output logic [DATA_W-1:0]       win_score,
  output logic [IDX_W-1:0]        win_lane
);

  function automatic logic signed [63:0] sext(input logic [DATA_W-1:0] v);
    return {{(64-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Fold lanes in ascending order so the lane offset doubles as the relative class index.
  always_comb begin
    win_score = lanes[DATA_W-1:0];
    win_lane  = {IDX_W{1'b0}};
    for (int l = 1; l < LANES; l++) begin
      if (better(sext(lanes[l*DATA_W +: DATA_W]), IDX_W'(l), sext(win_score), win_lane)) begin
        win_score = lanes[l*DATA_W +: DATA_W];
        win_lane  = IDX_W'(l);
      end else begin
        win_score = win_score;
        win_lane  = win_lane;
      end
    end
  end

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over NUM_CLASS signed scores delivered LANES per beat; reports 1-based winner.
// Optional ARGMAX_TIE_LOW_EN selects lowest-index tie resolution (default: highest index wins).
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_CLASS = 10,
  parameter int LANES     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_index,
  output logic [DATA_W-1:0]       out_max
);

  localparam int BEATS = NUM_CLASS / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  generate
    if ((NUM_CLASS % LANES) != 0) begin : g_bad_cfg
      $error("argmax_stream: NUM_CLASS must be a multiple of LANES");
    end
  endgenerate

  function automatic logic signed [63:0] sext(input logic [DATA_W-1:0] v);
    return {{(64-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [DATA_W-1:0]  best_max;
  logic [IDX_W-1:0]   best_idx;
  logic [DATA_W-1:0]  win_score;
  logic [IDX_W-1:0]   win_lane;
  logic [IDX_W-1:0]   cand_idx;
  logic [DATA_W-1:0]  new_max;
  logic [IDX_W-1:0]   new_idx;
  logic               accept;
  logic               last_beat;

  argmax_lane_tree #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_lane_tree (
    .lanes     (in_data),
    .win_score (win_score),
    .win_lane  (win_lane)
  );

  // Handshake strobes come from the state register only, never from out_ready.
  assign in_ready  = (state == RUN) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign cand_idx  = (IDX_W'(beat_cnt) * IDX_W'(LANES)) + win_lane + IDX_W'(1);

  // Merge the beat winner into the running best; beat 0 ignores the stale register.
  always_comb begin
    new_max = best_max;
    new_idx = best_idx;
    if ((beat_cnt == {CNT_W{1'b0}}) ||
        better(sext(win_score), cand_idx, sext(best_max), best_idx)) begin
      new_max = win_score;
      new_idx = cand_idx;
    end else begin
      new_max = best_max;
      new_idx = best_idx;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (accept && last_beat) next_state = DONE;
        else                     next_state = RUN;
      end
      DONE: begin
        if (out_ready) next_state = RUN;
        else           next_state = DONE;
      end
      default: next_state = RUN;
    endcase
  end

  // Beat counter, running best and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= {CNT_W{1'b0}};
      best_max  <= {DATA_W{1'b0}};
      best_idx  <= {IDX_W{1'b0}};
      out_index <= {IDX_W{1'b0}};
      out_max   <= {DATA_W{1'b0}};
    end else if (accept) begin
      if (last_beat) begin
        out_index <= new_idx;
        out_max   <= new_max;
        beat_cnt  <= {CNT_W{1'b0}};
      end else begin
        best_max  <= new_max;
        best_idx  <= new_idx;
        beat_cnt  <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_argmax_stream.sv
// Directed scoreboard bench for argmax_stream (NUM_CLASS=10, LANES=2, DATA_W=16).
// Tie expectations follow ARGMAX_TIE_LOW_EN when it is defined for the build.
module tb_argmax_stream;

  localparam int DATA_W    = 16;
  localparam int NUM_CLASS = 10;
  localparam int LANES     = 2;
  localparam int BEATS     = NUM_CLASS / LANES;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_index;
  logic [DATA_W-1:0]       out_max;

  typedef struct {
    logic [31:0] idx;
    logic [15:0] mx;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] sc[NUM_CLASS];
  int          checks   = 0;
  int          failures = 0;
  int          w;

  argmax_stream #(
    .DATA_W    (DATA_W),
    .NUM_CLASS (NUM_CLASS),
    .LANES     (LANES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_max   (out_max)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input int b, output int waits);
    in_valid = 1'b1;
    in_data  = {sc[2*b+1], sc[2*b]};
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) timeout_fail("beat_accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int first, input int gap, input logic [31:0] ei, input logic [15:0] em);
    int ww;
    exp_t e;
    for (int b = first; b < BEATS; b++) begin
      send_beat(b, ww);
      if (b == 1 && gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    e.idx = ei;
    e.mx  = em;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      timeout_fail({tag, "_sb_empty"});
    end else begin
      e = sb.pop_front();
      check({tag, "_index"}, 64'(out_index), 64'(e.idx));
      check({tag, "_max"}, 64'(out_max), 64'(e.mx));
    end
  endtask

  task automatic get_result(input string tag, output int waits);
    out_ready = 1'b1;
    waits     = 0;
    @(negedge clk);
    while (!out_valid && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!out_valid) timeout_fail({tag, "_out_valid"});
    else            pop_check(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_index", 64'(out_index), 64'd0);
    check("reset_out_max", 64'(out_max), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    sync();

    // Ascending scores, back-to-back beats.
    for (int k = 0; k < NUM_CLASS; k++) sc[k] = 16'(10 * (k + 1));
    send_frame(0, 0, 32'd10, 16'd100);
    get_result("asc", w);
    check("asc_latency", 64'(w), 64'd0);
    @(negedge clk);
    check("asc_in_ready_back", 64'(in_ready), 64'd1);
    sync();

    // Negative scores.
    for (int k = 0; k < NUM_CLASS; k++) sc[k] = 16'hFFFB;
    sc[2] = 16'hFFFF;
    send_frame(0, 0, 32'd3, 16'hFFFF);
    get_result("neg", w);

    // Tie between classes 2 and 7.
    for (int k = 0; k < NUM_CLASS; k++) sc[k] = 16'd0;
    sc[1] = 16'd50;
    sc[6] = 16'd50;
`ifdef ARGMAX_TIE_LOW_EN
    send_frame(0, 0, 32'd2, 16'd50);
`else
    send_frame(0, 0, 32'd7, 16'd50);
`endif
    get_result("tie", w);

    // Input gap plus output backpressure.
    for (int k = 0; k < NUM_CLASS; k++) sc[k] = 16'(10 * (k + 1));
    out_ready = 1'b0;
    send_frame(0, 3, 32'd10, 16'd100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_index", 64'(out_index), 64'd10);
      check("bp_out_max", 64'(out_max), 64'd100);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    sync();
    out_ready = 1'b1;
    @(negedge clk);
    pop_check("bp_result");
    sync();
    send_beat(0, w);
    check("bp_next_beat0_wait", 64'(w), 64'd0);
    send_frame(1, 0, 32'd10, 16'd100);
    get_result("bp_next", w);

    // Reset pulse after three beats.
    for (int b = 0; b < 3; b++) send_beat(b, w);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_index", 64'(out_index), 64'd0);
    check("midrst_in_ready_after", 64'(in_ready), 64'd1);
    sync();

    for (int k = 0; k < NUM_CLASS; k++) sc[k] = 16'd0;
    sc[0] = 16'd200;
    send_frame(0, 0, 32'd1, 16'd200);
    get_result("fresh", w);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/argmax_stream.md
# argmax_stream

Streaming, parametrised argmax unit for the classifier tail of the CNN pipeline. It accepts NUM_CLASS signed scores as a sequence of LANES-wide beats over a valid/ready handshake and keeps a running maximum. Once the frame is complete it presents the 1-based index of the winning class and its score. It replaces the fixed 10×16-bit combinational comparator and adds handshaking, backpressure, configurable width, class count and lane count, and a selectable tie policy.

## Interface
- DATA_W, 16: width of one signed score.
- NUM_CLASS, 10: scores per frame. Must be a multiple of LANES; elaboration fails otherwise.
- LANES, 2: scores per input beat.
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  reset, synchronous and active-high; one clock, reset is synchronous and active-high.
- in_valid  input  1  the beat on in_data is valid.
- in_ready  output  1  the block accepts a beat this cycle.
- in_data  input  LANES*DATA_W  scores; lane l occupies bits [l*DATA_W +: DATA_W].
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream takes the result.
- out_index  output  32  1-based winning class index, zero-extended.
- out_max  output  DATA_W  winning score, signed.

## Operation
- Class numbering: beat b (0-based within the frame), lane l → class b*LANES + l + 1. Lane 0 of beat 0 is class 1.
- FSM with two states:
  - RUN: in_ready = 1.
  - DONE: in_ready = 0, out_valid = 1.
- Beat accepted when in_valid && in_ready.
- beat_cnt has width $clog2(NUM_CLASS/LANES), with a minimum of 1.
- Within a beat, a lane tree finds the best lane. All compares are signed and follow the tie policy.
- First beat of a frame (beat_cnt == 0): the best register is loaded directly from the beat winner. Its stale contents are never compared.
- Later beats: the beat winner replaces the best register if it beats it under the tie policy. Classes in a later beat have higher indices than those already held.
- Tie policy, default: the higher index wins. Use >= where the candidate has the higher index.
- Accepting the last beat (beat_cnt == NUM_CLASS/LANES-1) does the following:
  - loads out_index and out_max from the final comparison;
  - resets beat_cnt to 0;
  - moves the FSM to DONE.
- DONE → RUN on out_valid && out_ready. out_index and out_max hold their values until the next frame completes.
- The result and score registers are not reset between frames. The first-beat load makes this safe.
- in_valid gaps between beats are allowed; state holds while no beat is accepted.

## Timing
- Reset values: state = RUN, beat_cnt = 0, out_valid = 0, out_index = 0, out_max = 0.
- While rst is high, in_ready = 0 and beats are ignored.
- rst high mid-frame or in DONE: the partial frame or pending result is discarded. The next accepted beat is beat 0.
- Latency: out_valid rises the cycle after the last beat is accepted.
- in_ready and out_valid are decoded from the registered state only. There is no combinational path from out_ready to in_ready.
- Peak throughput: one frame per NUM_CLASS/LANES + 1 cycles, assuming out_ready is held high.
- Backpressure: while out_valid && !out_ready, out_valid, out_index and out_max are stable and in_ready = 0.

## Configuration
- ARGMAX_TIE_LOW_EN:
  - Undefined: ties resolve to the highest class index.
  - Defined: ties resolve to the lowest class index. All compares become strict > where the candidate has the higher index, including inside the lane tree.
  - Nothing else changes: interface, latency and reset behaviour are identical.

## Structure
- Package argmax_pkg holds:
  - the state enum typedef (RUN, DONE);
  - localparam IDX_W = 32;
  - a compare function better(cand, cand_idx, best, best_idx) that implements the tie policy under the macro.
- Sub-module argmax_lane_tree, purely combinational:
  - input: LANES scores;
  - outputs: the winning lane score and the lane offset (0..LANES-1);
  - uses the same compare function.
- The top level holds the FSM, beat counter, running-best registers and output registers.

## Test plan
All scenarios use NUM_CLASS = 10, LANES = 2, DATA_W = 16 (5 beats per frame).
- Ascending scores: class k = 10*k, beats back-to-back, out_ready = 1 → out_index = 10 and out_max = 100 the cycle after beat 4 is accepted. in_ready returns to 1 the following cycle.
- Negative scores: all classes = -5 (0xFFFB) except class 3 = -1 → out_index = 3, out_max = 0xFFFF.
- Tie: classes 2 and 7 = 50, all others 0 → out_index = 7 with the macro undefined, out_index = 2 with ARGMAX_TIE_LOW_EN defined.
- Backpressure and stalls, with scores as in the first scenario:
  - in_valid is dropped for 3 cycles between beats 1 and 2 → same result as the ascending-scores case.
  - out_ready is held low for 4 cycles → out_valid, out_index and out_max are stable, and in_ready = 0 throughout.
  - The next frame's beat 0 is accepted the cycle after the handshake.
- Reset mid-frame:
  - rst is pulsed for 1 cycle after 3 beats → out_valid = 0, out_index = 0.
  - A fresh 5-beat frame with class 1 = 200 and all others 0 → out_index = 1, out_max = 200.
